// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and small decode helpers.
package muldiv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // funct3[2] splits the divide group from the multiply group
  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is taken as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_rs1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is taken as signed for MULH, DIV and REM
  function automatic logic op_rs2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for the M extension.
// One bit per cycle over a shared XLEN+1 adder and a 2*XLEN shift register.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            I_clk,
  input  logic            I_rst,
  input  logic            I_valid,
  output logic            O_ready,
  input  logic [2:0]      I_op,
  input  logic [XLEN-1:0] I_data1,
  input  logic [XLEN-1:0] I_data2,
  input  logic            I_kill,
  output logic            O_valid,
  output logic [XLEN-1:0] O_data
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned PW = 2 * XLEN;

  md_state_e       state, state_nxt;
  logic [2:0]      op_q, op_nxt;
  logic            neg_q, neg_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic [XLEN-1:0] hi, hi_nxt;
  logic [XLEN-1:0] lo, lo_nxt;
  logic [XLEN-1:0] opb, opb_nxt;
  logic            valid_nxt;
  logic [XLEN-1:0] data_nxt;

  // Accept-time decode of the incoming request
  logic            neg1, neg2, sign_in, div0, ovf;
  logic [XLEN-1:0] abs1, abs2, fast_res;

  always_comb begin
    neg1    = op_rs1_signed(I_op) & I_data1[XLEN-1];
    neg2    = op_rs2_signed(I_op) & I_data2[XLEN-1];
    abs1    = neg1 ? XLEN'(~I_data1 + XLEN'(1)) : I_data1;
    abs2    = neg2 ? XLEN'(~I_data2 + XLEN'(1)) : I_data2;
    sign_in = (I_op == MD_REM) ? neg1 : (neg1 ^ neg2);
    div0    = op_is_div(I_op) && (I_data2 == '0);
    ovf     = ((I_op == MD_DIV) || (I_op == MD_REM)) &&
              (I_data1 == {1'b1, {(XLEN-1){1'b0}}}) && (I_data2 == '1);
    if (div0) fast_res = I_op[1] ? I_data1 : '1;
    else      fast_res = I_op[1] ? '0 : I_data1;
  end

  // One iteration of the shared shift/add-subtract datapath
  logic            is_div;
  logic [XLEN:0]   add_a, add_b, sum, part;
  logic            qbit;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    is_div = op_is_div(op_q);
    add_a  = is_div ? {hi, lo[XLEN-1]} : {1'b0, hi};
    add_b  = is_div ? ~{1'b0, opb} : {1'b0, opb};
    sum    = (XLEN+1)'(add_a + add_b + (XLEN+1)'(is_div));
    part   = lo[0] ? sum : {1'b0, hi};
    qbit   = ~sum[XLEN];
    if (is_div) begin
      step_hi = qbit ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], qbit};
    end else begin
      step_hi = part[XLEN:1];
      step_lo = {part[0], lo[XLEN-1:1]};
    end
  end

  // Sign correction and result selection on the final iteration
  logic [PW-1:0]   prod, prod_c;
  logic [XLEN-1:0] quot_c, rem_c, final_res;

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_c = neg_q ? PW'(~prod + PW'(1)) : prod;
    quot_c = neg_q ? XLEN'(~step_lo + XLEN'(1)) : step_lo;
    rem_c  = neg_q ? XLEN'(~step_hi + XLEN'(1)) : step_hi;
    case (op_q)
      MD_MUL:                      final_res = prod_c[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_c[PW-1:XLEN];
      MD_DIV, MD_DIVU:             final_res = quot_c;
      default:                     final_res = rem_c;
    endcase
  end

  // Next-state and register-input logic
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    neg_nxt   = neg_q;
    count_nxt = count;
    hi_nxt    = hi;
    lo_nxt    = lo;
    opb_nxt   = opb;
    valid_nxt = 1'b0;
    data_nxt  = O_data;
    case (state)
      MD_IDLE: begin
        if (I_valid && !I_kill) begin
          op_nxt  = I_op;
          neg_nxt = sign_in;
          if (div0 || ovf) begin
            state_nxt = MD_DONE;
            valid_nxt = 1'b1;
            data_nxt  = fast_res;
          end else begin
            state_nxt = MD_CALC;
            count_nxt = CW'(XLEN);
            hi_nxt    = '0;
            lo_nxt    = op_is_div(I_op) ? abs1 : abs2;
            opb_nxt   = op_is_div(I_op) ? abs2 : abs1;
          end
        end
      end
      MD_CALC: begin
        if (I_kill) begin
          state_nxt = MD_IDLE;
        end else begin
          count_nxt = count - CW'(1);
          hi_nxt    = step_hi;
          lo_nxt    = step_lo;
          if (count == CW'(1)) begin
            state_nxt = MD_DONE;
            valid_nxt = 1'b1;
            data_nxt  = final_res;
          end
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state   <= MD_IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      opb     <= '0;
      O_valid <= 1'b0;
      O_data  <= '0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      neg_q   <= neg_nxt;
      count   <= count_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      opb     <= opb_nxt;
      O_valid <= valid_nxt;
      O_data  <= data_nxt;
    end
  end

  assign O_ready = (state == MD_IDLE) && !I_rst;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32): vector table plus kill, reset
// and held-request sequences, checking result, pulse timing and busy status.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            I_clk = 1'b0;
  logic            I_rst;
  logic            I_valid;
  logic            O_ready;
  logic [2:0]      I_op;
  logic [XLEN-1:0] I_data1;
  logic [XLEN-1:0] I_data2;
  logic            I_kill;
  logic            O_valid;
  logic [XLEN-1:0] O_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] prev_exp = '0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_valid(I_valid), .O_ready(O_ready),
    .I_op(I_op), .I_data1(I_data1), .I_data2(I_data2), .I_kill(I_kill),
    .O_valid(O_valid), .O_data(O_data)
  );

  always #5 I_clk = ~I_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    @(negedge I_clk);
    while (!O_ready && n < 100) begin
      @(negedge I_clk);
      n++;
    end
    chk({name, " ready wait"}, 32'(O_ready), 32'd1);
  endtask

  // lat = edges after the accept edge at which O_valid is first seen
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input bit hold,
                        input string name);
    int first, pulses, busy_bad;
    logic [31:0] got;
    wait_ready(name);
    I_op = op; I_data1 = a; I_data2 = b; I_valid = 1'b1;
    @(posedge I_clk); #1;
    if (hold) begin
      I_op = MD_MULHU; I_data1 = 32'd5; I_data2 = 32'd5;
    end else begin
      I_valid = 1'b0;
    end
    first = -1; pulses = 0; busy_bad = 0; got = '0;
    for (int k = 0; k <= int'(XLEN) + 3; k++) begin
      if (k > 0) begin
        @(posedge I_clk); #1;
      end
      if (O_valid) begin
        pulses++;
        if (first < 0) begin
          first = k;
          got = O_data;
        end
        I_valid = 1'b0;
      end
      if (k <= lat && O_ready) busy_bad++;
    end
    chk({name, " data"}, got, exp);
    chk({name, " latency"}, 32'(first), 32'(lat));
    chk({name, " pulses"}, 32'(pulses), 32'd1);
    chk({name, " busy"}, 32'(busy_bad), 32'd0);
    prev_exp = exp;
  endtask

  vec_t vecs[12];
  int   pulses;

  initial begin
    vecs[0]  = '{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 32, "mul 7*-3"};
    vecs[1]  = '{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32, "mulh min*min"};
    vecs[2]  = '{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, "mulhu ones"};
    vecs[3]  = '{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, "mulhsu ones"};
    vecs[4]  = '{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, "div -7/2"};
    vecs[5]  = '{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, "rem -7/2"};
    vecs[6]  = '{MD_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32, "divu big/2"};
    vecs[7]  = '{MD_REMU,   32'hFFFFFFF9, 32'd2,        32'd1,        32, "remu big/2"};
    vecs[8]  = '{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 0,  "divu 5/0"};
    vecs[9]  = '{MD_REMU,   32'd5,        32'd0,        32'd5,        0,  "remu 5/0"};
    vecs[10] = '{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  "div ovf"};
    vecs[11] = '{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0,  "rem ovf"};

    I_rst = 1'b1; I_valid = 1'b0; I_kill = 1'b0; I_op = '0; I_data1 = '0; I_data2 = '0;
    #1;
    chk("reset ready", 32'(O_ready), 32'd0);
    chk("reset valid", 32'(O_valid), 32'd0);
    chk("reset data", O_data, 32'd0);
    repeat (2) @(negedge I_clk);
    I_rst = 1'b0;
    #1;
    chk("ready after reset", 32'(O_ready), 32'd1);

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b0, vecs[i].name);

    // kill and valid together in IDLE: nothing accepted
    wait_ready("kill idle");
    I_op = MD_DIVU; I_data1 = 32'd5; I_data2 = 32'd0; I_valid = 1'b1; I_kill = 1'b1;
    @(posedge I_clk); #1;
    chk("kill idle ready", 32'(O_ready), 32'd1);
    chk("kill idle valid", 32'(O_valid), 32'd0);
    I_valid = 1'b0; I_kill = 1'b0;

    // kill in the 10th CALC cycle of DIV 100/7
    wait_ready("kill calc");
    I_op = MD_DIV; I_data1 = 32'd100; I_data2 = 32'd7; I_valid = 1'b1;
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    pulses = 0;
    repeat (9) begin
      @(posedge I_clk); #1;
      if (O_valid) pulses++;
    end
    I_kill = 1'b1;
    @(posedge I_clk); #1;
    I_kill = 1'b0;
    chk("kill calc ready", 32'(O_ready), 32'd1);
    repeat (5) begin
      if (O_valid) pulses++;
      @(posedge I_clk); #1;
    end
    chk("kill calc pulses", 32'(pulses), 32'd0);
    chk("kill calc data held", O_data, prev_exp);

    // new request held high while busy must be ignored
    run_op(MD_MUL, 32'd3, 32'd4, 32'd12, 32, 1'b1, "mul 3*4 held");

    // async reset mid-CALC
    wait_ready("reset calc");
    I_op = MD_DIV; I_data1 = 32'd100; I_data2 = 32'd7; I_valid = 1'b1;
    @(posedge I_clk); #1;
    I_valid = 1'b0;
    repeat (5) @(posedge I_clk);
    #1;
    I_rst = 1'b1;
    #1;
    chk("reset calc valid", 32'(O_valid), 32'd0);
    chk("reset calc data", O_data, 32'd0);
    chk("reset calc ready", 32'(O_ready), 32'd0);
    @(negedge I_clk);
    I_rst = 1'b0;
    #1;
    chk("reset calc ready after", 32'(O_ready), 32'd1);

    run_op(MD_DIV, 32'd100, 32'd7, 32'd14, 32, 1'b0, "div 100/7");
    run_op(MD_REM, 32'd100, 32'd7, 32'd2,  32, 1'b0, "rem 100/7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
